operand_fetch: RTL
==================

// Module: operand_fetch
// PURPOSE
//  Operand-fetch stage between the instruction decoder and the ALU. Accepts one decoded instruction,
//  reads up to two source registers through the single-port register_controller, and presents both
//  operands to the ALU. It also owns the register-file port for result writeback: writeback always wins the port.
// PARAMETERS
//  DATA_W    16  register/operand width
//  ADDR_W    4   register address width (matches register_controller address)
//  NUM_REGS  8   implemented registers; addresses >= NUM_REGS are unmapped
// PORTS
//  clock          in   1       rising-edge clock
//  reset_n        in   1       asynchronous active-low reset
//  dec_valid      in   1       decoded instruction available
//  dec_ready      out  1       stage accepts instruction (IDLE only)
//  dec_opcode     in   4       opcode, passed through to op_opcode
//  dec_src_a      in   ADDR_W  source register A
//  dec_src_b      in   ADDR_W  source register B
//  dec_use_b      in   1       1: fetch B; 0: op_b = 0
//  dec_dst        in   ADDR_W  destination, passed through to op_dst
//  op_valid       out  1       operands valid to ALU
//  op_ready       in   1       ALU accepts operands
//  op_a / op_b    out  DATA_W  operand A / operand B
//  op_opcode      out  4       latched opcode
//  op_dst         out  ADDR_W  latched destination
//  wb_valid       in   1       writeback request
//  wb_ready       out  1       writeback accepted (1 whenever reset_n=1)
//  wb_addr        in   ADDR_W  writeback register
//  wb_data        in   DATA_W  writeback value
//  rf_chip_enable out  1       to register_controller chip_enable
//  rf_write_enable out 1       to register_controller write_enable
//  rf_address     out  ADDR_W  to register_controller address
//  rf_value_in    out  DATA_W  to register_controller valueIn
//  rf_value_out   in   DATA_W  from register_controller valueOut; valid in cycle after read issue
// BEHAVIOUR
//  - Reset (async, reset_n=0): state IDLE; op_* and all rf_* outputs 0; op_valid=0, wb_ready=0.
//    Reset mid-operation abandons the instruction; no further port activity until a new dec handshake.
//  - Handshakes: transfer on valid&ready at the rising edge. dec_ready=1 only in IDLE.
//    op_valid=1 only in OUT. op_* stay stable while op_valid=1 and op_ready=0.
//  - FSM:
//    IDLE    -> ISSUE_A on dec_valid; latches opcode, src_a, src_b, use_b, dst.
//    ISSUE_A -> if wb_valid: port does write, stay; else drive read of src_a, go CAP_A.
//    CAP_A   -> op_a <= rf_value_out; go ISSUE_B if use_b, else OUT with op_b <= 0.
//    ISSUE_B -> same as ISSUE_A for src_b; go CAP_B.
//    CAP_B   -> op_b <= rf_value_out; go OUT.
//    OUT     -> IDLE when op_ready.
//  - Register port (combinational from state + wb inputs):
//    wb_valid & wb_addr<NUM_REGS: ce=1, we=1, addr=wb_addr, value_in=wb_data.
//    Else, in ISSUE_x: ce=1, we=0, addr=src_x. Otherwise ce=0, we=0, addr=0, value_in=0.
//  - Writeback has absolute priority. wb is accepted in every state; continuous wb_valid stalls ISSUE states indefinitely.
//  - Bypass: a wb accepted in CAP_x with wb_addr==src_x captures wb_data instead of rf_value_out.
//    wb after capture does not update a held operand (snapshot semantics).
//  - Unmapped addresses: source >= NUM_REGS gives operand 0 with ce=0 in that ISSUE cycle; FSM timing unchanged.
//    wb to an unmapped address is accepted and dropped, with ce=0.
//  - Latency, no wb interference, dec handshake at edge T:
//    use_b=1: op_valid first high in cycle T+5. use_b=0: op_valid first high in cycle T+3.
//    Back-to-back throughput is 1 instr / 6 cycles (use_b=1).
// TESTING
//  1. Preload R1=0x1234, R2=0xBEEF; dec src_a=1, src_b=2, use_b=1, dst=3, opcode=5
//     -> op_valid at T+5, op_a=0x1234, op_b=0xBEEF, op_dst=3, op_opcode=5; exactly 2 read cycles on rf port.
//  2. use_b=0, src_a=1 -> op_valid at T+3, op_b=0x0000, a single rf read.
//  3. Hold wb_valid (addr=4, data=0x00AA) for 3 cycles during ISSUE_A
//     -> 3 write cycles with ce=we=1; read issue slips 3 cycles; op_valid at T+8.
//  4. wb addr=1, data=0x5555 during CAP_A with src_a=1 -> op_a=0x5555; subsequent read of R1 returns 0x5555.
//  5. src_a=9 and wb_addr=12 -> op_a=0, no rf access for either; wb_ready=1; register contents unchanged.
//  6. op_ready=0 for 4 cycles in OUT -> op_* stable, dec_ready=0; reset_n pulse in ISSUE_B -> all outputs 0, state IDLE.

Source files
------------

// File: rtl/operand_fetch.sv
// Operand-fetch stage: reads up to two source registers through a single-port register file
// and hands both operands to the ALU. Writeback owns the port whenever it is requesting.
module operand_fetch #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned NUM_REGS = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  // decoder side
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [3:0]        dec_opcode,
  input  logic [ADDR_W-1:0] dec_src_a,
  input  logic [ADDR_W-1:0] dec_src_b,
  input  logic              dec_use_b,
  input  logic [ADDR_W-1:0] dec_dst,
  // ALU side
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [3:0]        op_opcode,
  output logic [ADDR_W-1:0] op_dst,
  // writeback
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  // register_controller port
  output logic              rf_chip_enable,
  output logic              rf_write_enable,
  output logic [ADDR_W-1:0] rf_address,
  output logic [DATA_W-1:0] rf_value_in,
  input  logic [DATA_W-1:0] rf_value_out
);

  typedef enum logic [2:0] {
    StIdle, StIssueA, StCapA, StIssueB, StCapB, StOut
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] src_a_q, src_b_q;
  logic              use_b_q;

  logic              wb_go, wb_map, issue, src_map, bypass;
  logic [ADDR_W-1:0] src_cur;
  logic [DATA_W-1:0] cap_val;

  function automatic logic is_mapped(input logic [ADDR_W-1:0] a);
    return 32'(a) < NUM_REGS;
  endfunction

  // Writeback is accepted whenever out of reset, even to unmapped addresses.
  assign wb_ready  = reset_n;
  assign wb_go     = wb_valid & reset_n;
  assign wb_map    = wb_go & is_mapped(wb_addr);
  assign dec_ready = reset_n & (state_q == StIdle);
  assign op_valid  = (state_q == StOut);

  assign src_cur = (state_q == StIssueB || state_q == StCapB) ? src_b_q : src_a_q;
  assign src_map = is_mapped(src_cur);
  assign issue   = (state_q == StIssueA || state_q == StIssueB) && !wb_go;
  assign bypass  = wb_map && (wb_addr == src_cur);

  // Unmapped sources read as zero; a same-cycle writeback to the source is forwarded.
  always_comb begin
    cap_val = rf_value_out;
    if (!src_map) begin
      cap_val = '0;
    end else if (bypass) begin
      cap_val = wb_data;
    end
  end

  always_comb begin
    rf_chip_enable  = 1'b0;
    rf_write_enable = 1'b0;
    rf_address      = '0;
    rf_value_in     = '0;
    if (wb_map) begin
      rf_chip_enable  = 1'b1;
      rf_write_enable = 1'b1;
      rf_address      = wb_addr;
      rf_value_in     = wb_data;
    end else if (issue && src_map) begin
      rf_chip_enable = 1'b1;
      rf_address     = src_cur;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (dec_valid) state_d = StIssueA;
      StIssueA: if (!wb_go) state_d = StCapA;
      StCapA:   state_d = use_b_q ? StIssueB : StOut;
      StIssueB: if (!wb_go) state_d = StCapB;
      StCapB:   state_d = StOut;
      StOut:    if (op_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      src_a_q   <= '0;
      src_b_q   <= '0;
      use_b_q   <= 1'b0;
      op_opcode <= '0;
      op_dst    <= '0;
      op_a      <= '0;
      op_b      <= '0;
    end else begin
      if (state_q == StIdle && dec_valid) begin
        src_a_q   <= dec_src_a;
        src_b_q   <= dec_src_b;
        use_b_q   <= dec_use_b;
        op_opcode <= dec_opcode;
        op_dst    <= dec_dst;
      end
      if (state_q == StCapA) begin
        op_a <= cap_val;
        if (!use_b_q) op_b <= '0;
      end
      if (state_q == StCapB) begin
        op_b <= cap_val;
      end
    end
  end

endmodule
